// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared state encoding and constants for the CPU bus master
package cpu_bus_pkg;

  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } bus_state_t;

  localparam int   PHASE_W  = 4;
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/cpu_bus_master.sv
// rtl/cpu_bus_master.sv - Famicom cartridge CPU bus initiator with free-running M2
module cpu_bus_master
  import cpu_bus_pkg::*;
#(
  parameter int          HALF_PERIOD  = 6,
  parameter int          ROMSEL_DELAY = 1,
  parameter int          WDATA_DELAY  = 1,
  parameter logic [15:0] IDLE_ADDR    = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        m2,
  output logic        romsel,
  output logic        cpu_rw,
  output logic [14:0] cpu_addr,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_data_oe,
  input  logic [7:0]  cpu_data_in
);

  localparam logic [PHASE_W-1:0] LAST_PH = PHASE_W'(HALF_PERIOD - 1);
  localparam logic [PHASE_W-1:0] RS_PH   = PHASE_W'(ROMSEL_DELAY);
  localparam logic [PHASE_W-1:0] WD_PH   = PHASE_W'(WDATA_DELAY);

  bus_state_t         state;
  bus_state_t         nxt_state;
  logic [PHASE_W-1:0] phase_cnt;
  logic [PHASE_W-1:0] nxt_phase;
  logic               last_clk;
  logic               nxt_high;
  logic               cycle_end;
  logic               bus_a15;
  logic               bus_active;

  always_comb begin
    last_clk  = (phase_cnt == LAST_PH);
    nxt_state = state;
    nxt_phase = phase_cnt + PHASE_W'(1);
    if (last_clk) begin
      nxt_phase = '0;
      nxt_state = (state == ST_LOW) ? ST_HIGH : ST_LOW;
    end
    nxt_high  = (nxt_state == ST_HIGH);
    cycle_end = (state == ST_HIGH) && last_clk;
  end

  // Every pin is computed from the next phase position so it is registered
  // yet lines up exactly with the clock index it belongs to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_LOW;
      phase_cnt    <= '0;
      m2           <= 1'b0;
      romsel       <= 1'b1;
      cpu_rw       <= RW_READ;
      cpu_addr     <= IDLE_ADDR[14:0];
      cpu_data_out <= 8'h00;
      cpu_data_oe  <= 1'b0;
      req_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 8'h00;
      bus_a15      <= 1'b0;
      bus_active   <= 1'b0;
    end else begin
      state       <= nxt_state;
      phase_cnt   <= nxt_phase;
      m2          <= nxt_high;
      romsel      <= !(nxt_high && (nxt_phase >= RS_PH) && bus_a15);
      cpu_data_oe <= nxt_high && (nxt_phase >= WD_PH) && (cpu_rw == RW_WRITE);
      req_ready   <= nxt_high && (nxt_phase == LAST_PH);
      rsp_valid   <= 1'b0;
      if (cycle_end) begin
        if (bus_active && (cpu_rw == RW_READ)) begin
          rsp_valid <= 1'b1;
          rsp_rdata <= cpu_data_in;
        end
        // Next M2 cycle carries the accepted request, or an idle read.
        if (req_valid && req_ready) begin
          cpu_addr     <= req_addr[14:0];
          cpu_rw       <= req_rw;
          bus_a15      <= req_addr[15];
          cpu_data_out <= (req_rw == RW_WRITE) ? req_wdata : 8'h00;
          bus_active   <= 1'b1;
        end else begin
          cpu_addr     <= IDLE_ADDR[14:0];
          cpu_rw       <= RW_READ;
          bus_a15      <= 1'b0;
          cpu_data_out <= 8'h00;
          bus_active   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_bus_master.sv
// tb/tb_cpu_bus_master.sv - self-checking bench for cpu_bus_master
module tb_cpu_bus_master;

  localparam int          HP   = 6;
  localparam int          RD   = 1;
  localparam int          WD   = 1;
  localparam logic [15:0] IDLE = 16'h0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_rw = 1'b1;
  logic [15:0] req_addr = 16'h0000;
  logic [7:0]  req_wdata = 8'h00;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        m2;
  logic        romsel;
  logic        cpu_rw;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_data_oe;
  logic [7:0]  cpu_data_in = 8'hA5;

  cpu_bus_master #(
    .HALF_PERIOD(HP), .ROMSEL_DELAY(RD), .WDATA_DELAY(WD), .IDLE_ADDR(IDLE)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .m2(m2), .romsel(romsel), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
    .cpu_data_out(cpu_data_out), .cpu_data_oe(cpu_data_oe),
    .cpu_data_in(cpu_data_in)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: t counts clocks since reset release; the M2 cycle holds one
  // transaction (m_v=0 means idle), chosen at the last HIGH clock.
  int         t = 0;
  logic       m_v = 1'b0;
  logic       m_rw = 1'b1;
  logic [15:0] m_addr = 16'h0000;
  logic [7:0] m_wd = 8'h00;
  logic       pend = 1'b0;
  logic [7:0] pend_d = 8'h00;
  logic [7:0] exp_rdata = 8'h00;

  int  rs_low, oe3c, rw_low, m2_hi;
  time rsp_t[$];
  bit  rnd = 1'b0;

  always @(negedge clk) begin
    int   idx, hidx;
    logic high, e_romsel, e_oe, e_rsp;
    if (!reset_n) begin
      chk("reset_outputs",
          48'({m2, romsel, cpu_rw, cpu_addr, cpu_data_out, cpu_data_oe, req_ready, rsp_valid, rsp_rdata}),
          48'({1'b0, 1'b1, 1'b1, 15'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00}));
      t = 0; m_v = 1'b0; pend = 1'b0; exp_rdata = 8'h00;
    end else begin
      idx      = t % (2 * HP);
      high     = (idx >= HP);
      hidx     = idx - HP;
      e_romsel = !(high && hidx >= RD && m_v && m_addr[15]);
      e_oe     = high && hidx >= WD && m_v && !m_rw;
      e_rsp    = (idx == 0) && pend;
      if (e_rsp) exp_rdata = pend_d;
      chk("m2", 48'(m2), 48'(high));
      chk("romsel", 48'(romsel), 48'(e_romsel));
      chk("cpu_rw", 48'(cpu_rw), 48'(m_v ? m_rw : 1'b1));
      chk("cpu_addr", 48'(cpu_addr), 48'(m_v ? m_addr[14:0] : IDLE[14:0]));
      chk("cpu_data_oe", 48'(cpu_data_oe), 48'(e_oe));
      if (e_oe) chk("cpu_data_out", 48'(cpu_data_out), 48'(m_wd));
      chk("req_ready", 48'(req_ready), 48'(high && hidx == HP - 1));
      chk("rsp_valid", 48'(rsp_valid), 48'(e_rsp));
      chk("rsp_rdata", 48'(rsp_rdata), 48'(exp_rdata));
      if (!romsel) rs_low++;
      if (cpu_data_oe && cpu_data_out == 8'h3C) oe3c++;
      if (!cpu_rw) rw_low++;
      if (m2) m2_hi++;
      if (rsp_valid) rsp_t.push_back($time);
      if (idx == 0) pend = 1'b0;
      if (idx == 2 * HP - 1) begin
        pend   = m_v && m_rw;
        pend_d = cpu_data_in;
        m_v    = req_valid;
        m_rw   = req_rw;
        m_addr = req_addr;
        m_wd   = req_wdata;
      end
      t++;
    end
  end

  task automatic clear_trk();
    rs_low = 0; oe3c = 0; rw_low = 0; m2_hi = 0;
    rsp_t.delete();
  endtask

  task automatic idle_clks(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (rnd) cpu_data_in = 8'($urandom);
    end
  endtask

  // acc_t marks the first LOW clock of the accepted transaction's M2 cycle.
  task automatic drive_req(input logic rw, input logic [15:0] a, input logic [7:0] d,
                           output time acc_t, output int waited);
    int n;
    n = 0;
    req_valid = 1'b1; req_rw = rw; req_addr = a; req_wdata = d;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 40) break;
      @(posedge clk); #1;
      if (rnd) cpu_data_in = 8'($urandom);
    end
    if (n > 40) chk("accept_timeout", 48'(0), 48'(1));
    acc_t  = $time + 10;
    waited = n + 1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (rnd) cpu_data_in = 8'($urandom);
  endtask

  task automatic wait_m2(input logic val);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m2 !== val && n < 40);
    if (n >= 40) chk("m2_timeout", 48'(m2), 48'(val));
  endtask

  initial begin
    time a1, a2, a3;
    int  w;
    clear_trk();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Three idle M2 cycles
    idle_clks(36);
    chk("idle_m2_high_clocks", 48'(m2_hi), 48'(18));
    chk("idle_romsel_low", 48'(rs_low), 48'(0));
    chk("idle_rw_low", 48'(rw_low), 48'(0));
    chk("idle_rsp_count", 48'(rsp_t.size()), 48'(0));

    // Read $8000 with A5 on the bus
    clear_trk();
    drive_req(1'b1, 16'h8000, 8'h00, a1, w);
    idle_clks(24);
    chk("read_romsel_low", 48'(rs_low), 48'(5));
    chk("read_rsp_count", 48'(rsp_t.size()), 48'(1));
    if (rsp_t.size() > 0) chk("read_latency", 48'(rsp_t[0] - a1), 48'(12 * 10));
    chk("read_rdata", 48'(rsp_rdata), 48'(8'hA5));

    // Write $6000 = 3C
    clear_trk();
    drive_req(1'b0, 16'h6000, 8'h3C, a1, w);
    idle_clks(24);
    chk("write_romsel_low", 48'(rs_low), 48'(0));
    chk("write_oe_clocks", 48'(oe3c), 48'(5));
    chk("write_rw_low", 48'(rw_low), 48'(12));
    chk("write_rsp_count", 48'(rsp_t.size()), 48'(0));

    // Back-to-back with valid held
    clear_trk();
    drive_req(1'b0, 16'h8001, 8'h80, a1, w);
    drive_req(1'b1, 16'hFFFC, 8'h00, a2, w);
    drive_req(1'b1, 16'h0000, 8'h00, a3, w);
    idle_clks(24);
    chk("b2b_gap_1", 48'(a2 - a1), 48'(120));
    chk("b2b_gap_2", 48'(a3 - a2), 48'(120));
    chk("b2b_romsel_low", 48'(rs_low), 48'(10));
    chk("b2b_rsp_count", 48'(rsp_t.size()), 48'(2));
    if (rsp_t.size() == 2) chk("b2b_rsp_spacing", 48'(rsp_t[1] - rsp_t[0]), 48'(120));

    // Reset during HIGH clock 3 of a $C000 read
    drive_req(1'b1, 16'hC000, 8'h00, a1, w);
    repeat (9) @(posedge clk);
    #1 chk("romsel_before_reset", 48'(romsel), 48'(0));
    #1 reset_n = 1'b0;
    #1 chk("reset_immediate", 48'({m2, romsel, cpu_data_oe}), 48'(3'b010));
    clear_trk();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("m2_after_release", 48'(m2), 48'(0));
    idle_clks(24);
    chk("abort_rsp_count", 48'(rsp_t.size()), 48'(0));

    // Request raised mid-LOW waits for the last HIGH clock
    wait_m2(1'b1);
    wait_m2(1'b0);
    repeat (2) @(posedge clk);
    #1;
    drive_req(1'b0, 16'h1234, 8'h5A, a1, w);
    chk("midlow_wait_clocks", 48'(w), 48'(10));
    chk("midlow_bus_addr", 48'(cpu_addr), 48'(15'h1234));
    chk("midlow_bus_rw", 48'(cpu_rw), 48'(0));
    idle_clks(12);

    // Randomized traffic with occasional resets
    rnd = 1'b1;
    repeat (60) begin
      idle_clks($urandom_range(0, 14));
      drive_req(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom), a1, w);
      if ($urandom_range(0, 9) == 0) begin
        idle_clks($urandom_range(0, 10));
        #1 reset_n = 1'b0;
        idle_clks(2);
        reset_n = 1'b1;
      end
    end
    idle_clks(24);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
